fetch_ctrl: RTL and testbench

- Fetch sequencer between the program counter/instruction memory and the decode stage.
- Generates sequential fetch addresses and issues them to instruction memory through a valid/ready request port.
- Collects in-order responses into a small queue and presents instruction+PC to decode with a valid/ready handshake.
- Handles branch/jump redirects (flush plus discard of in-flight responses) and a halt input that stops fetching.

---
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues sequential instruction-memory requests, queues in-order
// responses for decode, and handles redirect flush/discard and halt.
module fetch_ctrl #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   q_data [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic          req_pending;

   logic [CW:0]   in_use;
   logic          issue;
   logic          req_fire;
   logic          push;
   logic          pop;
   logic [CW-1:0] fire_inc;
   logic [CW-1:0] rsp_dec;
   logic [CW-1:0] outstanding_left;
   logic [31:0]   redirect_base;

   always_comb begin
      in_use           = {1'b0, outstanding} + {1'b0, count};
      // A held request must stay up regardless of halt or credit; only redirect withdraws it.
      issue            = !redirect_valid && (req_pending || (!halt && (in_use < DEPTH_W)));
      req_fire         = issue && imem_req_ready;
      push             = imem_rsp_valid && (discard == '0) && !redirect_valid;
      pop              = inst_valid && inst_ready;
      fire_inc         = {{(CW-1){1'b0}}, req_fire};
      rsp_dec          = {{(CW-1){1'b0}}, imem_rsp_valid};
      outstanding_left = outstanding - rsp_dec;
      redirect_base    = redirect_pc & ~32'h0000_0003;
   end

   assign imem_req_valid = reset && issue;
   assign imem_addr      = fetch_pc;
   assign inst_valid     = (count != '0);
   assign inst_data      = q_data[head];
   assign inst_pc        = q_pc[head];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         req_pending <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_data[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else if (redirect_valid) begin
         // Everything still in flight after this edge belongs to the old stream.
         fetch_pc    <= redirect_base;
         resp_pc     <= redirect_base;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         outstanding <= outstanding_left;
         discard     <= outstanding_left;
         req_pending <= 1'b0;
      end else begin
         if (req_fire) begin
            fetch_pc    <= fetch_pc + 32'd4;
            req_pending <= 1'b0;
         end else if (issue) begin
            req_pending <= 1'b1;
         end

         outstanding <= outstanding + fire_inc - rsp_dec;

         if (imem_rsp_valid && (discard != '0))
            discard <= discard - CW'(1);

         if (push) begin
            q_data[tail] <= imem_rsp_data;
            q_pc[tail]   <= resp_pc;
            tail         <= tail + PW'(1);
            resp_pc      <= resp_pc + 32'd4;
         end

         if (pop)
            head <= head + PW'(1);

         if (push && !pop)
            count <= count + CW'(1);
         else if (!push && pop)
            count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed and random traffic against an in-order memory
// model, with expected fetch/decode streams tracked per redirect epoch.
module tb_fetch_ctrl;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;

   fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } req_t;

   req_t        infl[$];
   logic [31:0] mq[$];
   logic [31:0] exp_addr = RESET_PC;
   logic        pend = 1'b0;
   int unsigned epoch = 0;
   int unsigned cyc = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int unsigned rsp_pct = 100;
   int          tests = 0;
   int          fails = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: called at a negedge with inputs already set.
   task automatic step();
      req_t r;
      logic exp_v;
      logic fire;
      if (infl.size() != 0 && infl[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(infl[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      exp_v = !redirect_valid && (pend || (!halt && (infl.size() + mq.size() < DEPTH)));
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_v});
      chk("imem_addr", imem_addr, exp_addr);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("inst_pc", inst_pc, mq[0]);
         chk("inst_data", inst_data, memf(mq[0]));
      end
      chk("credit", {31'b0, (infl.size() + mq.size()) <= DEPTH}, 32'd1);

      fire = imem_req_valid && imem_req_ready;
      if (inst_valid && inst_ready && mq.size() != 0)
         void'(mq.pop_front());
      if (imem_rsp_valid) begin
         r = infl.pop_front();
         if (r.epoch == epoch && !redirect_valid)
            mq.push_back(r.addr);
      end
      if (fire) begin
         infl.push_back('{addr: exp_addr, epoch: epoch, due: cyc + $urandom_range(lat_min, lat_max)});
         exp_addr = exp_addr + 32'd4;
      end
      pend = imem_req_valid && !imem_req_ready && !redirect_valid;
      if (redirect_valid) begin
         epoch++;
         mq.delete();
         exp_addr = {redirect_pc[31:2], 2'b00};
         pend = 1'b0;
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic check_reset_outputs();
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
   endtask

   task automatic model_clear();
      infl.delete();
      mq.delete();
      exp_addr = RESET_PC;
      pend = 1'b0;
      epoch++;
   endtask

   task automatic random_inputs(input int unsigned redir_pct);
      imem_req_ready = ($urandom_range(0, 99) < 70);
      inst_ready     = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 99) < redir_pct);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
   endtask

   initial begin
      // Reset held.
      repeat (2) @(negedge clock);
      #1;
      check_reset_outputs();
      @(negedge clock);
      reset = 1'b1;

      // Streaming with single-cycle memory and free decode.
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      repeat (20) step();

      // Decode stalls: only DEPTH requests may be in use, then resume.
      inst_ready = 1'b0;
      repeat (6) step();
      inst_ready = 1'b1;
      repeat (6) step();

      // Memory backpressure holds the request.
      imem_req_ready = 1'b0;
      repeat (3) step();
      imem_req_ready = 1'b1;
      repeat (6) step();

      // Redirect with requests in flight and slower memory.
      lat_min = 2;
      lat_max = 3;
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      step();
      redirect_valid = 1'b0;
      repeat (10) step();

      // Halt while a request is held.
      imem_req_ready = 1'b0;
      inst_ready     = 1'b1;
      repeat (2) step();
      halt = 1'b1;
      repeat (3) step();
      imem_req_ready = 1'b1;
      repeat (6) step();
      halt = 1'b0;
      repeat (6) step();

      // Random traffic, slow and fast memory.
      lat_min = 1;
      lat_max = 4;
      rsp_pct = 80;
      for (int i = 0; i < 2000; i++) begin
         random_inputs(3);
         step();
      end
      lat_max = 1;
      rsp_pct = 100;
      halt = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         random_inputs(8);
         step();
      end

      // Reset in the middle of traffic.
      redirect_valid = 1'b0;
      reset = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clock);
      model_clear();
      halt = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 200; i++) begin
         random_inputs(3);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
